// File: rtl/bids22_host.sv
// Host-side sequencer for the bids22 control port: expands one round descriptor into
// the unlock/load/lock command stream, runs the round and reports the outcome.
// Optional watchdog on the ready/roundOver waits: define BIDS22_HOST_WATCHDOG_EN.
module bids22_host #(
  parameter int DATAWIDTH = 32,
  parameter int ERRW      = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DATAWIDTH-1:0] req_key,
  input  logic [DATAWIDTH-1:0] req_xval,
  input  logic [DATAWIDTH-1:0] req_yval,
  input  logic [DATAWIDTH-1:0] req_zval,
  input  logic [DATAWIDTH-1:0] req_timer,
  input  logic [DATAWIDTH-1:0] req_bidcharge,
  input  logic [2:0]           req_mask,
  input  logic [15:0]          req_cycles,
  output logic [3:0]           C_op,
  output logic [DATAWIDTH-1:0] C_data,
  output logic                 C_start,
  input  logic                 ready,
  input  logic                 roundOver,
  input  logic [ERRW-1:0]      err,
  input  logic [DATAWIDTH-1:0] maxBid,
  output logic                 res_valid,
  output logic [1:0]           res_status,
  output logic [ERRW-1:0]      res_err,
  output logic [DATAWIDTH-1:0] res_maxbid
);

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_UNLOCK    = 4'd1;
  localparam logic [3:0] OP_LOCK      = 4'd2;
  localparam logic [3:0] OP_LOADX     = 4'd3;
  localparam logic [3:0] OP_LOADY     = 4'd4;
  localparam logic [3:0] OP_LOADZ     = 4'd5;
  localparam logic [3:0] OP_SETMASK   = 4'd6;
  localparam logic [3:0] OP_SETTIMER  = 4'd7;
  localparam logic [3:0] OP_SETCHARGE = 4'd8;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ENGERR  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UNLOCK    = 3'd1,
    S_LOAD      = 3'd2,
    S_LOCK      = 3'd3,
    S_WAITREADY = 3'd4,
    S_ROUND     = 3'd5,
    S_WAITOVER  = 3'd6,
    S_REPORT    = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  state_t               w_state_d;
  logic [2:0]           r_step;
  logic [15:0]          r_cnt;
  logic [DATAWIDTH-1:0] r_key, r_xval, r_yval, r_zval, r_timer, r_charge;
  logic [2:0]           r_mask;
  logic [15:0]          r_cycles;
  logic                 r_locked;
  logic [DATAWIDTH-1:0] r_last_key;
  logic [1:0]           r_res_status;
  logic [ERRW-1:0]      r_res_err;
  logic [DATAWIDTH-1:0] r_res_maxbid;
  logic [3:0]           w_op;
  logic [DATAWIDTH-1:0] w_data;
  logic                 w_start;
  logic                 w_err_abort;

`ifdef BIDS22_HOST_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] r_wd;
  logic           w_waiting;
  logic           w_wd_expire;

  assign w_waiting   = ((r_state == S_WAITREADY) && !ready) ||
                       ((r_state == S_WAITOVER) && !roundOver);
  assign w_wd_expire = w_waiting && (r_wd == WDW'(TIMEOUT - 1));

  // Watchdog: counts consecutive cycles spent waiting, restarts on any other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd <= {WDW{1'b0}};
    end else if (w_waiting) begin
      r_wd <= r_wd + {{(WDW-1){1'b0}}, 1'b1};
    end else begin
      r_wd <= {WDW{1'b0}};
    end
  end
`endif

  // Next-state and control-port decode; outputs depend only on registered state.
  always_comb begin
    w_next_state = r_state;
    w_op         = OP_NOP;
    w_data       = {DATAWIDTH{1'b0}};
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next_state = r_locked ? S_UNLOCK : S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_UNLOCK: begin
        w_op         = OP_UNLOCK;
        w_data       = r_last_key;
        w_next_state = S_LOAD;
      end
      S_LOAD: begin
        case (r_step)
          3'd0: begin w_op = OP_LOADX;     w_data = r_xval;   end
          3'd1: begin w_op = OP_LOADY;     w_data = r_yval;   end
          3'd2: begin w_op = OP_LOADZ;     w_data = r_zval;   end
          3'd3: begin w_op = OP_SETMASK;   w_data = {{(DATAWIDTH-3){1'b0}}, r_mask}; end
          3'd4: begin w_op = OP_SETTIMER;  w_data = r_timer;  end
          3'd5: begin w_op = OP_SETCHARGE; w_data = r_charge; end
          default: begin w_op = OP_NOP; w_data = {DATAWIDTH{1'b0}}; end
        endcase
        if (r_step >= 3'd5) begin
          w_next_state = S_LOCK;
        end else begin
          w_next_state = S_LOAD;
        end
      end
      S_LOCK: begin
        w_op         = OP_LOCK;
        w_data       = r_key;
        w_next_state = S_WAITREADY;
      end
      S_WAITREADY: begin
        if (ready) begin
          w_next_state = S_ROUND;
        end else begin
`ifdef BIDS22_HOST_WATCHDOG_EN
          w_next_state = w_wd_expire ? S_REPORT : S_WAITREADY;
`else
          w_next_state = S_WAITREADY;
`endif
        end
      end
      S_ROUND: begin
        w_start = 1'b1;
        if (r_cnt <= 16'd1) begin
          w_next_state = S_WAITOVER;
        end else begin
          w_next_state = S_ROUND;
        end
      end
      S_WAITOVER: begin
        if (roundOver) begin
          w_next_state = S_REPORT;
        end else begin
`ifdef BIDS22_HOST_WATCHDOG_EN
          w_next_state = w_wd_expire ? S_REPORT : S_WAITOVER;
`else
          w_next_state = S_WAITOVER;
`endif
        end
      end
      S_REPORT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Any issued opcode answered with a nonzero err ends the sequence at once.
  assign w_err_abort = (w_op != OP_NOP) && (err != {ERRW{1'b0}});
  assign w_state_d   = w_err_abort ? S_REPORT : w_next_state;

  // State, descriptor latch, sequencing counters, lock tracking and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_step       <= 3'd0;
      r_cnt        <= 16'd0;
      r_key        <= {DATAWIDTH{1'b0}};
      r_xval       <= {DATAWIDTH{1'b0}};
      r_yval       <= {DATAWIDTH{1'b0}};
      r_zval       <= {DATAWIDTH{1'b0}};
      r_timer      <= {DATAWIDTH{1'b0}};
      r_charge     <= {DATAWIDTH{1'b0}};
      r_mask       <= 3'd0;
      r_cycles     <= 16'd0;
      r_locked     <= 1'b0;
      r_last_key   <= {DATAWIDTH{1'b0}};
      r_res_status <= ST_OK;
      r_res_err    <= {ERRW{1'b0}};
      r_res_maxbid <= {DATAWIDTH{1'b0}};
    end else begin
      r_state <= w_state_d;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_key    <= req_key;
            r_xval   <= req_xval;
            r_yval   <= req_yval;
            r_zval   <= req_zval;
            r_timer  <= req_timer;
            r_charge <= req_bidcharge;
            r_mask   <= req_mask;
            r_cycles <= req_cycles;
            r_step   <= 3'd0;
          end else begin
            r_step   <= 3'd0;
          end
        end
        S_UNLOCK: r_locked <= 1'b0;
        S_LOAD:   r_step   <= r_step + 3'd1;
        S_LOCK: begin
          if (!w_err_abort) begin
            r_locked   <= 1'b1;
            r_last_key <= r_key;
          end else begin
            r_locked   <= r_locked;
          end
        end
        S_WAITREADY: begin
          if (ready) begin
            r_cnt <= (r_cycles == 16'd0) ? 16'd1 : r_cycles;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_ROUND: r_cnt <= r_cnt - 16'd1;
        default: r_cnt <= r_cnt;
      endcase
      // Result registers change only on the way into REPORT and hold otherwise.
      if (w_err_abort) begin
        r_res_status <= ST_ENGERR;
        r_res_err    <= err;
        r_res_maxbid <= {DATAWIDTH{1'b0}};
      end else if ((r_state == S_WAITOVER) && roundOver) begin
        r_res_status <= ST_OK;
        r_res_err    <= {ERRW{1'b0}};
        r_res_maxbid <= maxBid;
`ifdef BIDS22_HOST_WATCHDOG_EN
      end else if (w_wd_expire) begin
        r_res_status <= ST_TIMEOUT;
        r_res_err    <= {ERRW{1'b0}};
        r_res_maxbid <= {DATAWIDTH{1'b0}};
`endif
      end else begin
        r_res_status <= r_res_status;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign C_op       = w_op;
  assign C_data     = w_data;
  assign C_start    = w_start;
  assign res_valid  = (r_state == S_REPORT);
  assign res_status = r_res_status;
  assign res_err    = r_res_err;
  assign res_maxbid = r_res_maxbid;

endmodule

// File: tb/tb_bids22_host.sv
// Scoreboard bench for bids22_host: a request-level model predicts the command stream,
// the C_start length and the result; monitors pop and compare as the DUT presents them.
module tb_bids22_host;
  localparam int DW = 32;
  localparam int EW = 3;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_key, req_xval, req_yval, req_zval, req_timer, req_bidcharge;
  logic [2:0]    req_mask;
  logic [15:0]   req_cycles;
  logic [3:0]    C_op;
  logic [DW-1:0] C_data;
  logic          C_start;
  logic          ready;
  logic          roundOver;
  logic [EW-1:0] err;
  logic [DW-1:0] maxBid;
  logic          res_valid;
  logic [1:0]    res_status;
  logic [EW-1:0] res_err;
  logic [DW-1:0] res_maxbid;

  bids22_host #(.DATAWIDTH(DW), .ERRW(EW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_xval(req_xval), .req_yval(req_yval), .req_zval(req_zval),
    .req_timer(req_timer), .req_bidcharge(req_bidcharge), .req_mask(req_mask),
    .req_cycles(req_cycles), .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .ready(ready), .roundOver(roundOver), .err(err), .maxBid(maxBid),
    .res_valid(res_valid), .res_status(res_status), .res_err(res_err),
    .res_maxbid(res_maxbid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [3:0] op; logic [DW-1:0] data; int at; } op_t;
  typedef struct { logic [1:0] st; logic [EW-1:0] e; logic [DW-1:0] mb; } res_t;
  op_t  op_q[$];
  res_t res_q[$];
  int   len_q[$];

  // request-level model state of the engine lock
  bit            m_locked = 1'b0;
  logic [DW-1:0] m_last_key = '0;

  // engine stub: err answers the injected opcode
  logic [3:0]    inj_op  = 4'd0;
  logic [EW-1:0] inj_val = 3'd0;
  assign err = (inj_op != 4'd0 && C_op == inj_op) ? inj_val : 3'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // op monitor
  op_t mo;
  always @(negedge clk) begin
    if (!reset) begin
      if (C_op != 4'd0) begin
        if (op_q.size() == 0) begin
          chk("op_unexpected", 64'(C_op), 64'd0);
        end else begin
          mo = op_q.pop_front();
          chk("op_code", 64'(C_op), 64'(mo.op));
          chk("op_data", 64'(C_data), 64'(mo.data));
          chk("op_cycle", 64'(cyc), 64'(mo.at));
        end
      end else begin
        chk("nop_data", 64'(C_data), 64'd0);
      end
    end
  end

  // result monitor
  res_t mr;
  always @(negedge clk) begin
    if (res_valid) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 64'(res_valid), 64'd0);
      end else begin
        mr = res_q.pop_front();
        chk("res_status", 64'(res_status), 64'(mr.st));
        chk("res_err", 64'(res_err), 64'(mr.e));
        chk("res_maxbid", 64'(res_maxbid), 64'(mr.mb));
      end
    end
  end

  // C_start run-length monitor
  int run = 0;
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
      len_q.delete();
    end else if (C_start) begin
      run++;
    end else if (run > 0) begin
      if (len_q.size() == 0) chk("start_unexpected", 64'(run), 64'd0);
      else chk("start_len", 64'(run), 64'(len_q.pop_front()));
      run = 0;
    end
  end

  // engine stub: pulse roundOver a random 0..3 cycles after C_start drops
  bit prev_start = 1'b0;
  bit armed = 1'b0;
  int ro_wait = 0;
  always @(negedge clk) begin
    if (prev_start && !C_start) begin
      armed   = 1'b1;
      ro_wait = $urandom_range(0, 3);
    end
    if (armed && ro_wait == 0) begin
      roundOver = 1'b1;
      armed     = 1'b0;
    end else begin
      roundOver = 1'b0;
      if (armed) ro_wait--;
    end
    prev_start = C_start;
  end

  task automatic issue(input logic [DW-1:0] key, x, y, z, tm, ch, input logic [2:0] mask,
                       input logic [15:0] ncyc, input logic [3:0] iop, input logic [EW-1:0] ival,
                       input logic [DW-1:0] mb, input bit hold);
    op_t  seq[$];
    res_t r;
    bit   aborted = 1'b0;
    int   wt = 0;
    int   hs;
    @(negedge clk);
    while (!req_ready && wt < 300) begin @(negedge clk); wt++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    inj_op = iop; inj_val = ival; maxBid = mb;
    if (m_locked) seq.push_back('{4'd1, m_last_key, 0});
    seq.push_back('{4'd3, x, 0});
    seq.push_back('{4'd4, y, 0});
    seq.push_back('{4'd5, z, 0});
    seq.push_back('{4'd6, {29'd0, mask}, 0});
    seq.push_back('{4'd7, tm, 0});
    seq.push_back('{4'd8, ch, 0});
    seq.push_back('{4'd2, key, 0});
    req_key = key; req_xval = x; req_yval = y; req_zval = z; req_timer = tm;
    req_bidcharge = ch; req_mask = mask; req_cycles = ncyc; req_valid = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    req_valid = 1'b0;
    for (int i = 0; i < seq.size(); i++) begin
      seq[i].at = hs + i;
      op_q.push_back(seq[i]);
      if (seq[i].op == 4'd1) m_locked = 1'b0;
      if (seq[i].op == iop && ival != 3'd0) begin
        aborted = 1'b1;
        r = '{2'd1, ival, '0};
        break;
      end
      if (seq[i].op == 4'd2) begin
        m_locked = 1'b1;
        m_last_key = key;
      end
    end
    if (!aborted) begin
`ifdef BIDS22_HOST_WATCHDOG_EN
      if (hold) r = '{2'd2, 3'd0, '0};
      else begin
        len_q.push_back((ncyc == 16'd0) ? 1 : int'(ncyc));
        r = '{2'd0, 3'd0, mb};
      end
`else
      len_q.push_back((ncyc == 16'd0) ? 1 : int'(ncyc));
      r = '{2'd0, 3'd0, mb};
`endif
    end
    res_q.push_back(r);
  endtask

  task automatic wait_done();
    int wt = 0;
    while ((res_q.size() != 0 || op_q.size() != 0) && wt < 2000) begin
      @(negedge clk); wt++;
    end
    chk("res_drain", 64'(res_q.size()), 64'd0);
    chk("op_drain", 64'(op_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; ready = 1'b1; maxBid = '0;
    req_key = '0; req_xval = '0; req_yval = '0; req_zval = '0; req_timer = '0;
    req_bidcharge = '0; req_mask = 3'd0; req_cycles = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_c_op", 64'(C_op), 64'd0);
    chk("rst_c_data", 64'(C_data), 64'd0);
    chk("rst_c_start", 64'(C_start), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_status", 64'(res_status), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_res_maxbid", 64'(res_maxbid), 64'd0);
    reset = 1'b0;

    // directed: first request, identical second (adds UNLOCK), then SETMASK error
    issue(32'hA5, 32'd100, 32'd200, 32'd50, 32'd15, 32'd1, 3'd7, 16'd4, 4'd0, 3'd0, 32'd42, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("res_hold", 64'(res_maxbid), 64'd42);
    issue(32'hA5, 32'd100, 32'd200, 32'd50, 32'd15, 32'd1, 3'd7, 16'd4, 4'd0, 3'd0, 32'd42, 1'b0);
    wait_done();
    issue(32'h5A, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 3'd3, 16'd2, 4'd6, 3'd3, 32'd9, 1'b0);
    wait_done();
    // zero-length round, also shows the failed request left the lock clear
    issue(32'h77, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 3'd1, 16'd0, 4'd0, 3'd0, 32'd1234, 1'b0);
    wait_done();

    // randomized requests with occasional engine errors
    for (int k = 0; k < 25; k++) begin
      logic [3:0]    iop;
      logic [EW-1:0] iv;
      iop = 4'd0; iv = 3'd0;
      if ($urandom_range(0, 3) == 0) begin
        iop = 4'($urandom_range(1, 8));
        iv  = 3'($urandom_range(1, 7));
      end
      issue($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            3'($urandom_range(0, 7)), 16'($urandom_range(0, 12)), iop, iv, $urandom, 1'b0);
      wait_done();
    end

    // ready withheld past the watchdog interval
    ready = 1'b0;
    issue(32'hC3, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 3'd5, 16'd3, 4'd0, 3'd0, 32'd77, 1'b1);
`ifdef BIDS22_HOST_WATCHDOG_EN
    wait_done();
    ready = 1'b1;
`else
    repeat (TO + 20) @(negedge clk);
    chk("wait_no_result", 64'(res_q.size()), 64'd1);
    chk("wait_busy", 64'(req_ready), 64'd0);
    chk("wait_no_start", 64'(C_start), 64'd0);
    ready = 1'b1;
    wait_done();
`endif

    // reset in the middle of a round
    issue(32'hE1, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 3'd2, 16'd10, 4'd0, 3'd0, 32'd55, 1'b0);
    begin
      int wt = 0;
      while (!C_start && wt < 300) begin @(negedge clk); wt++; end
      chk("round_started", 64'(C_start), 64'd1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_c_start", 64'(C_start), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_res_maxbid", 64'(res_maxbid), 64'd0);
    reset = 1'b0;
    res_q.delete();
    chk("midrst_ops_done", 64'(op_q.size()), 64'd0);
    op_q.delete();
    m_locked = 1'b0;
    m_last_key = '0;
    repeat (15) @(negedge clk);
    chk("midrst_quiet", 64'(res_valid), 64'd0);

    // after reset the lock is clear again: no UNLOCK expected
    issue(32'h3C, 32'd11, 32'd22, 32'd33, 32'd44, 32'd55, 3'd6, 16'd5, 4'd0, 3'd0, 32'd99, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bids22_host.md
# bids22_host

Host-side sequencer for the bids22 auction engine's control port (C_op/C_data/C_start). It accepts one round descriptor per handshake and expands it into the full command sequence: unlock, load the three bidder balances, set mask, cooldown timer and bid charge, then lock. It then waits for `ready`, holds `C_start` for the requested round length, waits for `roundOver`, and returns `maxBid` or a failure status. It sits between the testbench/system controller and the bids22 control interface.

## Interface
- `DATAWIDTH`, 32, width of C_data, balances, key, maxBid
- `ERRW`, 3, width of the engine's `err` code (0 = NOERROR)
- `TIMEOUT`, 64, cycles allowed waiting for `ready` or `roundOver`
- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `req_valid` in 1 — round descriptor valid
- `req_ready` out 1 — host idle, descriptor accepted when both high
- `req_key`, `req_xval`, `req_yval`, `req_zval`, `req_timer`, `req_bidcharge` in DATAWIDTH each — descriptor fields
- `req_mask` in 3 — bidder mask (bit0 = X)
- `req_cycles` in 16 — C_start high-time in cycles; 0 treated as 1
- `C_op` out 4 — opcode: NO_OP=0, UNLOCK=1, LOCK=2, LOADX=3, LOADY=4, LOADZ=5, SETMASK=6, SETTIMER=7, SETBIDCHARGE=8
- `C_data` out DATAWIDTH — operand for C_op
- `C_start` out 1 — round active
- `ready`, `roundOver` in 1 — engine status
- `err` in ERRW — engine error code
- `maxBid` in DATAWIDTH — winning bid, valid with `roundOver`
- `res_valid` out 1 — one-cycle result pulse
- `res_status` out 2 — 0 OK, 1 ENGINE_ERR, 2 TIMEOUT
- `res_err` out ERRW — engine `err` captured on abort, else 0
- `res_maxbid` out DATAWIDTH — captured `maxBid` when OK, else 0

## Operation
- States: IDLE, UNLOCK, LOAD, LOCK, WAITREADY, ROUND, WAITOVER, REPORT.
- IDLE: `req_ready`=1. On handshake, latch all fields into registers, go UNLOCK if `locked` flag set, else LOAD with step=0.
- UNLOCK: drive UNLOCK with `last_key` for one cycle, clear `locked`, go LOAD.
- LOAD: step counter 0..5 drives LOADX, LOADY, LOADZ, SETMASK (zero-extended), SETTIMER, SETBIDCHARGE, one per cycle; after step 5 go LOCK.
- LOCK: drive LOCK with latched key for one cycle; set `locked`, `last_key`; go WAITREADY.
- `err` is sampled in every cycle a non-NO_OP opcode is driven; nonzero → capture into `res_err`, status ENGINE_ERR, go REPORT. No further ops are issued. `locked` is set only if the LOCK itself returned 0.
- WAITREADY: C_op=NO_OP; `ready`=1 → load round counter with max(req_cycles,1), go ROUND.
- ROUND: `C_start`=1, counter decrements each cycle; on the cycle the counter reaches 1, go WAITOVER.
- WAITOVER: `C_start`=0; `roundOver`=1 → capture `maxBid`, status OK, go REPORT.
- REPORT: `res_valid`=1 for exactly one cycle, go IDLE. Result registers hold until the next REPORT.
- Outputs outside their active states: C_op=NO_OP, C_data=0, C_start=0.

## Timing
- Reset: state IDLE, `req_ready`=1, C_op=0, C_data=0, C_start=0, res_valid=0, res_status=0, res_err=0, res_maxbid=0, `locked`=0, `last_key`=0, all counters 0. `reset` mid-sequence aborts immediately with no result pulse.
- Handshake to first op: 1 cycle. First request (unlocked): 6 load + 1 lock = ops in cycles 1..7 after the handshake; subsequent requests add a leading UNLOCK (8 ops).
- `req_valid` while busy is ignored (`req_ready`=0); no queueing.
- C_start is high for exactly max(req_cycles,1) consecutive cycles.
- Simultaneous `roundOver` and timeout expiry: `roundOver` wins.
- `ready` high on the same cycle LOCK is driven is ignored; it is sampled from the first WAITREADY cycle onward.

## Configuration
- `BIDS22_HOST_WATCHDOG_EN` defined: a cycle counter runs in WAITREADY and WAITOVER. After TIMEOUT cycles without the awaited input, status TIMEOUT and go REPORT. C_start is forced 0. On a TIMEOUT from WAITREADY, `locked` is kept set.
- Undefined: no counter; the host waits indefinitely. Status 2 is never produced.

## Test plan
- Reset, request x=100,y=200,z=50,mask=7,timer=15,charge=1,key=0xA5,cycles=4 → ops LOADX..SETBIDCHARGE,LOCK(0xA5) on consecutive cycles; C_start high 4 cycles; roundOver with maxBid=42 → res_valid, status 0, res_maxbid=42.
- Second identical request → first op UNLOCK with C_data=0xA5, then the same 7 ops.
- Engine returns err=3 during SETMASK → no SETTIMER issued; status 1, res_err=3, `locked` remains 0.
- req_cycles=0 → C_start high exactly 1 cycle.
- Watchdog build, `ready` held 0 → res_valid at TIMEOUT cycles after entering WAITREADY, status 2; non-watchdog build remains in WAITREADY.
- Assert `reset` during ROUND → C_start=0 and req_ready=1 next cycle, no res_valid.
